// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start_i        request, accepted only while idle
//   dividend_i     unsigned numerator, sampled on acceptance
//   divisor_i      unsigned denominator, sampled on acceptance
//   busy_o         high while iterating
//   done_o         one-cycle pulse, results valid
//   quotient_o     quotient, held until the next done
//   remainder_o    remainder, held until the next done
//   div_by_zero_o  divisor was zero for the reported result
//
// A division accepted at edge E0 iterates on E1..E<WIDTH>; done_o is high for
// the cycle after the last iteration, then the block returns to idle.
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_out_q, dbz_out_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  // One restoring step. The partial remainder stays below the divisor, so the
  // shifted value is under 2*divisor and a WIDTH+1 bit trial never overflows:
  // its top bit is a true sign bit. With divisor 0 the shifted value never
  // reaches bit WIDTH, so the trial is always kept (quotient all ones).
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_q};
    trial_ok = ~trial[WIDTH];
    rem_step = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {dvd_q[WIDTH-2:0], trial_ok};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    dbz_d     = dbz_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_out_d = dbz_out_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          cnt_d   = CntInit;
          rem_d   = '0;
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          dbz_d   = (divisor_i == '0);
        end
      end
      StRun: begin
        rem_d = rem_step;
        dvd_d = quo_step;
        cnt_d = cnt_q - CntLast;
        if (cnt_q == CntLast) begin
          state_d   = StDone;
          quo_out_d = quo_step;
          rem_out_d = rem_step;
          dbz_out_d = dbz_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      dbz_q     <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      dbz_q     <= dbz_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign busy_o        = (state_q == StRun);
  assign done_o        = (state_q == StDone);
  assign quotient_o    = quo_out_q;
  assign remainder_o   = rem_out_q;
  assign div_by_zero_o = dbz_out_q;

endmodule
